seq_divider: RTL and testbench

//  Iterative signed divider: the inverse of the registered 2W-bit multiplier in the FFT datapath.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/seq_divider_if.sv | 27 ++
 rtl/seq_divider.sv | 170 +++++++++++++++++
 tb/tb_seq_divider.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath types and constants
// Divider state encoding, default operand width and saturation limits.
package fft_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int SAT_BITS   = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_t;

  // Callers truncate these to W bits to get 0x7F..F and 0x80..0.
  function automatic logic [SAT_BITS-1:0] q_max(input int w);
    return (SAT_BITS'(1) << (w - 1)) - SAT_BITS'(1);
  endfunction

  function automatic logic [SAT_BITS-1:0] q_min(input int w);
    return SAT_BITS'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/done handshake and result bundle for seq_divider
// The requester holds the master side; the divider holds the slave side.
interface seq_divider_if #(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH
);

  logic                      start;
  logic [2*DATA_WIDTH-1:0]   dividend;
  logic [DATA_WIDTH-1:0]     divisor;
  logic                      busy;
  logic                      done;
  logic [DATA_WIDTH-1:0]     quotient;
  logic [DATA_WIDTH-1:0]     remainder;
  logic                      div_by_zero;
  logic                      overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative signed divider, 2W-bit dividend by W-bit divisor
// Restoring division on magnitudes, one quotient bit per cycle; signs and saturation applied in FIX.
module seq_divider #(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH
) (
  input logic          clk,
  input logic          aclr,
  seq_divider_if.slave bus
);

  import fft_pkg::*;

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W);
  localparam logic [W-1:0] Q_MAX = W'(q_max(W));
  localparam logic [W-1:0] Q_MIN = W'(q_min(W));

  function automatic logic [2*W-1:0] abs_wide(input logic [2*W-1:0] v);
    return v[2*W-1] ? -v : v;
  endfunction

  function automatic logic [W-1:0] abs_narrow(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  function automatic logic [W-1:0] apply_sign(input logic [W-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  div_state_t       state;
  div_state_t       state_next;

  logic [2*W-1:0]   dvd_abs;
  logic [W-1:0]     dsr_abs;
  logic             dsr_zero;
  logic             early_ovf;

  logic [W-1:0]     dsr_mag;
  logic [W-1:0]     low_bits;
  logic [W-1:0]     rem;
  logic [W-1:0]     quo;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;
  logic             pend_dbz;
  logic             pend_ovf;

  logic [W:0]       trial;
  logic             trial_ge;
  logic [W-1:0]     rem_step;

  logic             fix_ovf;
  logic [W-1:0]     q_fix;
  logic [W-1:0]     r_fix;

  assign dvd_abs   = abs_wide(bus.dividend);
  assign dsr_abs   = abs_narrow(bus.divisor);
  assign dsr_zero  = (bus.divisor == '0);
  // Upper half >= divisor means the magnitude quotient needs more than W bits.
  assign early_ovf = !dsr_zero && (dvd_abs[2*W-1:W] >= dsr_abs);

  assign trial    = {rem, low_bits[W-1]};
  assign trial_ge = (trial >= {1'b0, dsr_mag});
  assign rem_step = trial_ge ? W'(trial - {1'b0, dsr_mag}) : trial[W-1:0];

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (dsr_zero || early_ovf) begin
            state_next = FIX;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    fix_ovf = 1'b0;
    q_fix   = '0;
    r_fix   = '0;
    if (pend_dbz) begin
      fix_ovf = 1'b0;
    end else if (pend_ovf || (!sign_q && (quo > Q_MAX)) || (sign_q && (quo > Q_MIN))) begin
      fix_ovf = 1'b1;
      q_fix   = sign_q ? Q_MIN : Q_MAX;
    end else begin
      q_fix = apply_sign(quo, sign_q);
      r_fix = apply_sign(rem, sign_r);
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      dsr_mag         <= '0;
      low_bits        <= '0;
      rem             <= '0;
      quo             <= '0;
      cnt             <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      pend_dbz        <= 1'b0;
      pend_ovf        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dsr_mag  <= dsr_abs;
            rem      <= dvd_abs[2*W-1:W];
            low_bits <= dvd_abs[W-1:0];
            quo      <= '0;
            cnt      <= CNT_W'(W - 1);
            sign_q   <= bus.dividend[2*W-1] ^ bus.divisor[W-1];
            sign_r   <= bus.dividend[2*W-1];
            pend_dbz <= dsr_zero;
            pend_ovf <= early_ovf;
            bus.busy <= 1'b1;
          end
        end
        CALC: begin
          rem      <= rem_step;
          quo      <= {quo[W-2:0], trial_ge};
          low_bits <= {low_bits[W-2:0], 1'b0};
          cnt      <= cnt - CNT_W'(1);
        end
        FIX: begin
          bus.quotient    <= q_fix;
          bus.remainder   <= r_fix;
          bus.div_by_zero <= pend_dbz;
          bus.overflow    <= fix_ovf;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
        end
        default: begin
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
// Wide-integer reference model with per-cycle compare, directed cases and random traffic.
module tb_seq_divider;

  localparam int W = 32;

  logic clk  = 1'b0;
  logic aclr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_divider_if #(.DATA_WIDTH(W)) bus ();

  seq_divider #(.DATA_WIDTH(W)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_dbz  = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [W-1:0] m_q    = '0;
  logic [W-1:0] m_r    = '0;
  int           m_left = 0;
  logic [W-1:0] p_q    = '0;
  logic [W-1:0] p_r    = '0;
  logic         p_dbz  = 1'b0;
  logic         p_ovf  = 1'b0;
  logic         p_early = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // True quotient/remainder in 128-bit signed arithmetic, then saturate.
  task automatic ref_div(input logic [63:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dbz, output logic ovf, output logic early);
    logic signed [127:0] aa, bb, qq, rr, ma, mb;
    aa = {{64{a[63]}}, a};
    bb = {{96{b[31]}}, b};
    q = '0; r = '0; dbz = 1'b0; ovf = 1'b0; early = 1'b0;
    if (b == '0) begin
      dbz   = 1'b1;
      early = 1'b1;
    end else begin
      qq = aa / bb;
      rr = aa % bb;
      ma = (aa < 0) ? -aa : aa;
      mb = (bb < 0) ? -bb : bb;
      early = (ma >= (mb << 32));
      if (qq > 128'sd2147483647 || qq < -128'sd2147483648) begin
        ovf = 1'b1;
        q   = (qq < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        q = qq[31:0];
        r = rr[31:0];
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge aclr);
    if (!aclr) begin
      m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      m_q = '0; m_r = '0; m_dbz = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_ovf = p_ovf;
        end
      end else if (bus.start) begin
        ref_div(bus.dividend, bus.divisor, p_q, p_r, p_dbz, p_ovf, p_early);
        m_busy = 1'b1;
        m_left = p_early ? 1 : W + 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cyc.busy", 64'(bus.busy), 64'(m_busy));
    chk("cyc.done", 64'(bus.done), 64'(m_done));
    chk("cyc.quotient", 64'(bus.quotient), 64'(m_q));
    chk("cyc.remainder", 64'(bus.remainder), 64'(m_r));
    chk("cyc.div_by_zero", 64'(bus.div_by_zero), 64'(m_dbz));
    chk("cyc.overflow", 64'(bus.overflow), 64'(m_ovf));
  end

  task automatic pin(input string name, input logic [63:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er,
                     input logic edbz, input logic eovf, input logic eearly);
    logic [31:0] q, r;
    logic dbz, ovf, early;
    ref_div(a, b, q, r, dbz, ovf, early);
    chk({name, ".q"}, 64'(q), 64'(eq));
    chk({name, ".r"}, 64'(r), 64'(er));
    chk({name, ".dbz"}, 64'(dbz), 64'(edbz));
    chk({name, ".ovf"}, 64'(ovf), 64'(eovf));
    chk({name, ".early"}, 64'(early), 64'(eearly));
  endtask

  task automatic drive(input logic [63:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int edges, output int bcyc);
    edges = 0;
    bcyc  = 0;
    while (!bus.done && edges < bound) begin
      if (bus.busy) bcyc++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!bus.done) chk("wait_done.timeout", 64'(bus.done), 64'd1);
  endtask

  task automatic run_check(input string name, input logic [63:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz, input logic eovf, input int elat, input logic gap);
    int edges, bcyc;
    if (gap) @(negedge clk);
    drive(a, b);
    wait_done(200, edges, bcyc);
    chk({name, ".latency"}, 64'(edges), 64'(elat));
    chk({name, ".busy_cycles"}, 64'(bcyc), 64'(elat));
    chk({name, ".q"}, 64'(bus.quotient), 64'(eq));
    chk({name, ".r"}, 64'(bus.remainder), 64'(er));
    chk({name, ".dbz"}, 64'(bus.div_by_zero), 64'(edbz));
    chk({name, ".ovf"}, 64'(bus.overflow), 64'(eovf));
  endtask

  task automatic rand_operands();
    longint a;
    longint qt;
    int     b;
    b = int'($urandom);
    case ($urandom_range(0, 6))
      0: begin
        a = longint'($urandom_range(0, 2000)) - 1000;
        b = int'($urandom_range(1, 40));
        if ($urandom_range(0, 1) != 0) b = -b;
      end
      1: a = longint'({$urandom, $urandom});
      2: begin
        a = longint'(int'($urandom));
        b = 0;
      end
      3: begin
        a = longint'(int'($urandom)) * 2;
        b = ($urandom_range(0, 1) != 0) ? 1 : -1;
      end
      4: begin
        case ($urandom_range(0, 3))
          0: qt = 64'sd2147483647;
          1: qt = -64'sd2147483648;
          2: qt = 64'sd2147483648;
          default: qt = -64'sd2147483649;
        endcase
        if (b == 0) b = 5;
        a = longint'(b) * qt + longint'($urandom_range(0, 3));
      end
      5: begin
        a = longint'(64'h8000_0000_0000_0000);
        if ($urandom_range(0, 1) != 0) b = -1;
      end
      default: begin
        a = longint'(int'($urandom));
        b = int'($urandom) >>> $urandom_range(0, 30);
      end
    endcase
    bus.dividend = a;
    bus.divisor  = b;
  endtask

  initial begin
    int edges, bcyc;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    pin("model.100_7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
    pin("model.m100_7", -64'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    pin("model.100_m7", 64'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, 1'b0);
    pin("model.m2p31_m1", -64'sd2147483648, -32'sd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0);
    pin("model.2p40_1", 64'd1 << 40, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b1);

    @(negedge clk);
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.done", 64'(bus.done), 64'd0);
    chk("reset.quotient", 64'(bus.quotient), 64'd0);
    chk("reset.remainder", 64'(bus.remainder), 64'd0);
    chk("reset.flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
    repeat (2) @(negedge clk);
    aclr = 1'b1;

    run_check("t1.100_7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, W + 1, 1'b1);
    run_check("t2.m100_7", -64'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, W + 1, 1'b1);
    run_check("t2.100_m7", 64'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, W + 1, 1'b1);
    run_check("t2.mul_inv", -64'sd97406784, -32'sd789, 32'd123456, 32'd0, 1'b0, 1'b0, W + 1, 1'b1);
    run_check("t3.div0", 64'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    run_check("t4.early_ovf", 64'd1 << 40, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1, 1'b1);
    run_check("t4.fix_ovf", -64'sd2147483648, -32'sd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, W + 1, 1'b1);
    run_check("t4.min_q", 64'd2147483648, -32'sd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, W + 1, 1'b1);
    run_check("t4.most_neg", 64'h8000_0000_0000_0000, 32'd3, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1, 1'b1);

    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 64'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    repeat (12) begin
      @(negedge clk);
      bus.dividend = {$urandom, $urandom};
      bus.divisor  = $urandom;
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(200, edges, bcyc);
    chk("t5.hold.q", 64'(bus.quotient), 64'd14);
    chk("t5.hold.r", 64'(bus.remainder), 64'd2);

    run_check("t5.first", 64'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, W + 1, 1'b1);
    run_check("t5.on_done", -64'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, W + 1, 1'b0);

    @(negedge clk);
    drive(64'd1000, 32'd3);
    repeat (9) @(negedge clk);
    aclr = 1'b0;
    #1;
    chk("t6.abort.busy", 64'(bus.busy), 64'd0);
    chk("t6.abort.done", 64'(bus.done), 64'd0);
    chk("t6.abort.quotient", 64'(bus.quotient), 64'd0);
    chk("t6.abort.remainder", 64'(bus.remainder), 64'd0);
    chk("t6.abort.flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t6.abort.no_done", 64'(bus.done), 64'd0);
    end
    aclr = 1'b1;
    run_check("t6.after", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, W + 1, 1'b1);

    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      rand_operands();
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
